// File: rtl/rv32_pipeline_pkg.sv
// rtl/rv32_pipeline_pkg.sv - shared rv32 pipeline types for the ID/EX boundary
// Contents: word_t, reg_addr_t, forward_sel_t, FWD_SEL_W, id_ex_payload_t.
package rv32_pipeline_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int FWD_SEL_W    = 2;
    // Width of the opaque decoded control bundle carried in the payload struct.
    localparam int ID_EX_CTRL_W = 16;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } forward_sel_t;

    typedef struct packed {
        word_t                   pc;
        reg_addr_t               rs1;
        reg_addr_t               rs2;
        reg_addr_t               rd;
        word_t                   imm;
        logic [ID_EX_CTRL_W-1:0] ctrl;
        logic                    regwrite;
        logic                    mem_read;
    } id_ex_payload_t;

endpackage

// File: rtl/operand_resolve.sv
// rtl/operand_resolve.sv - picks one source operand from regfile, forwards or shadow
// Ports: sel_i forward select, rs_i register index, rf_data_i regfile data,
//        mem_data_i/wb_data_i forward sources, shadow_data_i/shadow_valid_i
//        held forward value, operand_o resolved operand.
module operand_resolve
    import rv32_pipeline_pkg::*;
(
    input  forward_sel_t sel_i,
    input  reg_addr_t    rs_i,
    input  word_t        rf_data_i,
    input  word_t        mem_data_i,
    input  word_t        wb_data_i,
    input  word_t        shadow_data_i,
    input  logic         shadow_valid_i,
    output word_t        operand_o
);

    always_comb begin
        operand_o = rf_data_i;
        if (rs_i == '0) begin
            // x0 is hardwired zero whatever the hazard logic says.
            operand_o = '0;
        end else begin
            case (sel_i)
                FWD_MEM: operand_o = mem_data_i;
                FWD_WB:  operand_o = wb_data_i;
                default: begin
                    // A live forward beats the shadow; the shadow beats a stale regfile read.
                    if (shadow_valid_i) begin
                        operand_o = shadow_data_i;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with operand forwarding and shadows
// Ports: id_* decoded ID instruction and regfile data, forward_rs1/2 selects,
//        mem_fwd_data/wb_fwd_data forward sources, id_ex_stall/id_ex_bubble/flush
//        controls, ex_* registered EX payload, stall_count/bubble_count counters.
module id_ex_stage
    import rv32_pipeline_pkg::*;
#(
    // Must equal ID_EX_CTRL_W: the control bundle travels inside id_ex_payload_t.
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  word_t             id_pc,
    input  reg_addr_t         id_rs1,
    input  reg_addr_t         id_rs2,
    input  reg_addr_t         id_rd,
    input  word_t             id_rs1_data,
    input  word_t             id_rs2_data,
    input  word_t             id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_regwrite,
    input  logic              id_mem_read,
    input  forward_sel_t      forward_rs1,
    input  forward_sel_t      forward_rs2,
    input  word_t             mem_fwd_data,
    input  word_t             wb_fwd_data,
    input  logic              id_ex_stall,
    input  logic              id_ex_bubble,
    input  logic              flush,
    output logic              ex_valid,
    output word_t             ex_pc,
    output word_t             ex_imm,
    output word_t             ex_op1,
    output word_t             ex_op2,
    output reg_addr_t         ex_rs1,
    output reg_addr_t         ex_rs2,
    output reg_addr_t         ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_regwrite,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
);

    id_ex_payload_t   pay_q, pay_d, id_pay;
    logic             valid_q, valid_d;
    word_t            op1_q, op1_d, op2_q, op2_d;
    word_t            sh1_q, sh1_d, sh2_q, sh2_d;
    logic             sh1_v_q, sh1_v_d, sh2_v_q, sh2_v_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    word_t            op1_res, op2_res;
    logic             hold_id;

    operand_resolve u_rs1 (
        .sel_i          (forward_rs1),
        .rs_i           (id_rs1),
        .rf_data_i      (id_rs1_data),
        .mem_data_i     (mem_fwd_data),
        .wb_data_i      (wb_fwd_data),
        .shadow_data_i  (sh1_q),
        .shadow_valid_i (sh1_v_q),
        .operand_o      (op1_res)
    );

    operand_resolve u_rs2 (
        .sel_i          (forward_rs2),
        .rs_i           (id_rs2),
        .rf_data_i      (id_rs2_data),
        .mem_data_i     (mem_fwd_data),
        .wb_data_i      (wb_fwd_data),
        .shadow_data_i  (sh2_q),
        .shadow_valid_i (sh2_v_q),
        .operand_o      (op2_res)
    );

    // ID instruction stays put this cycle, so any forward seen now must be remembered.
    assign hold_id = (id_ex_stall | id_ex_bubble) & ~flush;

    always_comb begin
        id_pay          = '{pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd, imm: id_imm,
                            ctrl: id_ctrl, regwrite: id_regwrite, mem_read: id_mem_read};
        pay_d           = pay_q;
        valid_d         = valid_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        sh1_d           = sh1_q;
        sh2_d           = sh2_q;
        sh1_v_d         = sh1_v_q;
        sh2_v_d         = sh2_v_q;
        stall_cnt_d     = stall_cnt_q;
        bubble_cnt_d    = bubble_cnt_q;

        if (flush || id_ex_bubble) begin
            valid_d        = 1'b0;
            pay_d.regwrite = 1'b0;
            pay_d.mem_read = 1'b0;
            pay_d.ctrl     = '0;
            if (flush) begin
                sh1_v_d = 1'b0;
                sh2_v_d = 1'b0;
            end
        end else if (!id_ex_stall) begin
            pay_d          = id_pay;
            // Side-effect flags never survive into EX without a valid instruction.
            pay_d.regwrite = id_regwrite & id_valid;
            pay_d.mem_read = id_mem_read & id_valid;
            valid_d        = id_valid;
            op1_d          = op1_res;
            op2_d          = op2_res;
            sh1_v_d        = 1'b0;
            sh2_v_d        = 1'b0;
        end

        // Newest producer wins: a later non-NONE select overwrites the shadow.
        if (hold_id) begin
            if (forward_rs1 != FWD_NONE) begin
                sh1_d   = op1_res;
                sh1_v_d = 1'b1;
            end
            if (forward_rs2 != FWD_NONE) begin
                sh2_d   = op2_res;
                sh2_v_d = 1'b1;
            end
        end

        if (id_ex_stall && !id_ex_bubble && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (id_ex_bubble && !flush && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_q        <= '0;
            valid_q      <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            sh1_q        <= '0;
            sh2_q        <= '0;
            sh1_v_q      <= 1'b0;
            sh2_v_q      <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pay_q        <= pay_d;
            valid_q      <= valid_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            sh1_q        <= sh1_d;
            sh2_q        <= sh2_d;
            sh1_v_q      <= sh1_v_d;
            sh2_v_q      <= sh2_v_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pay_q.pc;
    assign ex_imm       = pay_q.imm;
    assign ex_op1       = op1_q;
    assign ex_op2       = op2_q;
    assign ex_rs1       = pay_q.rs1;
    assign ex_rs2       = pay_q.rs2;
    assign ex_rd        = pay_q.rd;
    assign ex_ctrl      = pay_q.ctrl;
    assign ex_regwrite  = pay_q.regwrite;
    assign ex_mem_read  = pay_q.mem_read;
    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import rv32_pipeline_pkg::*;

    localparam int CTRL_W = 16;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    word_t             id_pc;
    reg_addr_t         id_rs1, id_rs2, id_rd;
    word_t             id_rs1_data, id_rs2_data, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_regwrite, id_mem_read;
    forward_sel_t      forward_rs1, forward_rs2;
    word_t             mem_fwd_data, wb_fwd_data;
    logic              id_ex_stall, id_ex_bubble, flush;
    logic              ex_valid;
    word_t             ex_pc, ex_imm, ex_op1, ex_op2;
    reg_addr_t         ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_regwrite, ex_mem_read;
    logic [CNT_W-1:0]  stall_count, bubble_count;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_regwrite  (id_regwrite),
        .id_mem_read  (id_mem_read),
        .forward_rs1  (forward_rs1),
        .forward_rs2  (forward_rs2),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_data  (wb_fwd_data),
        .id_ex_stall  (id_ex_stall),
        .id_ex_bubble (id_ex_bubble),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .ex_regwrite  (ex_regwrite),
        .ex_mem_read  (ex_mem_read),
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid     = 1'b0;
        id_pc        = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_rs1_data  = '0;
        id_rs2_data  = '0;
        id_imm       = '0;
        id_ctrl      = '0;
        id_regwrite  = 1'b0;
        id_mem_read  = 1'b0;
        forward_rs1  = FWD_NONE;
        forward_rs2  = FWD_NONE;
        mem_fwd_data = '0;
        wb_fwd_data  = '0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        // Reset state
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_op1", ex_op1, 0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 0);
        check("rst_stall_cnt", 32'(stall_count), 0);
        check("rst_bubble_cnt", 32'(bubble_count), 0);
        rst_n = 1'b1;
        tick();

        // Plain load
        id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd5; id_rs1_data = 32'h11;
        id_rd = 5'd3; id_imm = 32'h44; id_ctrl = 16'hBEEF; id_regwrite = 1'b1; id_mem_read = 1'b1;
        tick();
        check("load_valid", 32'(ex_valid), 1);
        check("load_pc", ex_pc, 32'h100);
        check("load_op1", ex_op1, 32'h11);
        check("load_imm", ex_imm, 32'h44);
        check("load_rd", 32'(ex_rd), 3);
        check("load_ctrl", 32'(ex_ctrl), 32'hBEEF);
        check("load_regwrite", 32'(ex_regwrite), 1);
        check("load_mem_read", 32'(ex_mem_read), 1);

        // MEM forward, then x0 override
        forward_rs1 = FWD_MEM; mem_fwd_data = 32'hAAAA_0001;
        tick();
        check("memfwd_op1", ex_op1, 32'hAAAA_0001);
        id_rs1 = 5'd0;
        tick();
        check("memfwd_x0_op1", ex_op1, 0);

        // Shadow hold across a stall
        do_reset();
        id_valid = 1'b1; id_pc = 32'h200; id_rs2 = 5'd6; id_rs2_data = 32'h1;
        tick();
        check("sh_pre_pc", ex_pc, 32'h200);
        id_pc = 32'h204; id_ex_stall = 1'b1; forward_rs2 = FWD_WB; wb_fwd_data = 32'h55;
        tick();
        check("sh_stall_hold_pc", ex_pc, 32'h200);
        check("sh_stall_hold_op2", ex_op2, 32'h1);
        check("sh_stall_cnt", 32'(stall_count), 1);
        id_ex_stall = 1'b0; forward_rs2 = FWD_NONE; wb_fwd_data = '0; id_rs2_data = 32'h0;
        tick();
        check("sh_release_pc", ex_pc, 32'h204);
        check("sh_release_op2", ex_op2, 32'h55);
        check("sh_release_cnt", 32'(stall_count), 1);

        // Newest producer overwrites the shadow; counter saturates at 3
        id_ex_stall = 1'b1; forward_rs2 = FWD_WB; wb_fwd_data = 32'h55;
        tick();
        forward_rs2 = FWD_MEM; mem_fwd_data = 32'h66;
        tick();
        forward_rs2 = FWD_NONE; mem_fwd_data = '0; wb_fwd_data = '0;
        tick();
        check("newest_sat_cnt", 32'(stall_count), 3);
        id_ex_stall = 1'b0;
        tick();
        check("newest_op2", ex_op2, 32'h66);
        id_rs2_data = 32'h22;
        tick();
        check("shadow_cleared_op2", ex_op2, 32'h22);

        // Bubble together with stall; shadow survives the bubble
        do_reset();
        id_valid = 1'b1; id_pc = 32'h300; id_regwrite = 1'b1; id_ctrl = 16'h1234;
        tick();
        id_ex_stall = 1'b1; id_ex_bubble = 1'b1;
        id_rs1 = 5'd7; forward_rs1 = FWD_MEM; mem_fwd_data = 32'h123;
        tick();
        check("bub_valid", 32'(ex_valid), 0);
        check("bub_regwrite", 32'(ex_regwrite), 0);
        check("bub_ctrl", 32'(ex_ctrl), 0);
        check("bub_bubble_cnt", 32'(bubble_count), 1);
        check("bub_stall_cnt", 32'(stall_count), 0);
        id_ex_stall = 1'b0; id_ex_bubble = 1'b0; forward_rs1 = FWD_NONE;
        mem_fwd_data = '0; id_rs1_data = 32'h0;
        tick();
        check("bub_shadow_op1", ex_op1, 32'h123);
        check("bub_reload_valid", 32'(ex_valid), 1);

        // Flush beats stall and drops the shadow
        do_reset();
        id_valid = 1'b1; id_rs1 = 5'd7; id_ex_stall = 1'b1;
        forward_rs1 = FWD_WB; wb_fwd_data = 32'h9;
        tick();
        flush = 1'b1; forward_rs1 = FWD_NONE; wb_fwd_data = '0;
        tick();
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_stall_cnt", 32'(stall_count), 1);
        flush = 1'b0; id_ex_stall = 1'b0; id_rs1_data = 32'h7;
        tick();
        check("flush_reload_op1", ex_op1, 32'h7);
        check("flush_reload_valid", 32'(ex_valid), 1);

        // Async reset mid-stall after counter saturation
        do_reset();
        id_valid = 1'b1; id_pc = 32'h300; id_rs1 = 5'd1; id_rs1_data = 32'h5;
        tick();
        id_ex_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sat_stall_cnt", 32'(stall_count), 3);
        check("sat_hold_pc", ex_pc, 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(ex_valid), 0);
        check("async_pc", ex_pc, 0);
        check("async_op1", ex_op1, 0);
        check("async_stall_cnt", 32'(stall_count), 0);
        id_ex_stall = 1'b0; id_pc = 32'h400; id_rs1_data = 32'h8;
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(ex_valid), 1);
        check("post_rst_pc", ex_pc, 32'h400);
        check("post_rst_op1", ex_op1, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
